// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the byte-bus FPU sequencer:
// register map, opcodes and sequencer state encoding.
package pa_fpu;

    localparam logic [5:0] ADDR_A0   = 6'h00;
    localparam logic [5:0] ADDR_B0   = 6'h04;
    localparam logic [5:0] ADDR_OP   = 6'h08;
    localparam logic [5:0] ADDR_RES0 = 6'h0C;

    localparam logic [7:0] op_add = 8'h01;
    localparam logic [7:0] op_sub = 8'h02;
    localparam logic [7:0] op_mul = 8'h03;
    localparam logic [7:0] op_div = 8'h04;

    typedef enum logic [3:0] {
        IDLE,
        WR_STB,
        WR_GAP,
        WAIT_END,
        RD_STB,
        RD_SMP,
        RD_GAP,
        ACK,
        RESP
    } state_t;

endpackage

// File: rtl/fpu_seq.sv
// Sequencer driving a byte-wide FPU register bus: writes A, B and the
// opcode, waits for cmd_end (with timeout), reads the 32-bit result back.
// Ports:
//   clk, arst                 clock, synchronous active-high reset
//   req_*                     request handshake and operands
//   rsp_*                     response handshake, result, timeout flag
//   fpu_data_o/i, fpu_addr    FPU byte bus and register address
//   fpu_cs_n/rd_n/wr_n        active-low strobes
//   fpu_end_ack               acknowledge of fpu_cmd_end
//   fpu_cmd_end, fpu_busy     FPU status
module fpu_seq
    import pa_fpu::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic [7:0]  fpu_data_o,
    input  logic [7:0]  fpu_data_i,
    output logic [5:0]  fpu_addr,
    output logic        fpu_cs_n,
    output logic        fpu_rd_n,
    output logic        fpu_wr_n,
    output logic        fpu_end_ack,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_res;
    logic          r_tmo;
    logic          w_accept;
    logic [7:0]    w_wr_byte;
    logic          w_expire;

    assign w_accept = req_valid && req_ready;
    assign w_expire = (r_cnt == TMO_LAST);

    // Byte index 0..3 selects A, 4..7 selects B, 8 the opcode.
    always_comb begin
        w_wr_byte = r_op;
        if (r_idx < 4'd4) begin
            w_wr_byte = r_a[{r_idx[1:0], 3'b000} +: 8];
        end else if (r_idx < 4'd8) begin
            w_wr_byte = r_b[{r_idx[1:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        fpu_cs_n    = 1'b1;
        fpu_rd_n    = 1'b1;
        fpu_wr_n    = 1'b1;
        fpu_end_ack = 1'b0;
        fpu_addr    = 6'h00;
        fpu_data_o  = 8'h00;
        unique case (r_state)
            IDLE: begin
                req_ready = !arst && !fpu_cmd_end && !fpu_busy;
                if (w_accept) begin
                    w_next = WR_STB;
                end
            end
            WR_STB: begin
                fpu_cs_n   = 1'b0;
                fpu_wr_n   = 1'b0;
                fpu_addr   = ADDR_A0 + {2'b00, r_idx};
                fpu_data_o = w_wr_byte;
                w_next     = WR_GAP;
            end
            WR_GAP: begin
                fpu_addr   = ADDR_A0 + {2'b00, r_idx};
                fpu_data_o = w_wr_byte;
                w_next     = (r_idx == 4'd8) ? WAIT_END : WR_STB;
            end
            WAIT_END: begin
                // cmd_end takes priority over an expiring counter
                if (fpu_cmd_end) begin
                    w_next = RD_STB;
                end else if (w_expire) begin
                    w_next = RESP;
                end
            end
            RD_STB: begin
                fpu_cs_n = 1'b0;
                fpu_rd_n = 1'b0;
                fpu_addr = ADDR_RES0 + {2'b00, r_idx};
                w_next   = RD_SMP;
            end
            RD_SMP: begin
                fpu_cs_n = 1'b0;
                fpu_rd_n = 1'b0;
                fpu_addr = ADDR_RES0 + {2'b00, r_idx};
                w_next   = RD_GAP;
            end
            RD_GAP: begin
                fpu_addr = ADDR_RES0 + {2'b00, r_idx};
                w_next   = (r_idx == 4'd3) ? ACK : RD_STB;
            end
            ACK: begin
                fpu_end_ack = 1'b1;
                if (!fpu_cmd_end) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_idx <= 4'd0;
            r_cnt <= '0;
            r_op  <= 8'h00;
            r_a   <= 32'h0;
            r_b   <= 32'h0;
            r_res <= 32'h0;
            r_tmo <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= req_op;
                        r_a   <= req_a;
                        r_b   <= req_b;
                        r_idx <= 4'd0;
                        r_res <= 32'h0;
                        r_tmo <= 1'b0;
                    end
                end
                WR_GAP: begin
                    r_cnt <= '0;
                    r_idx <= (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
                end
                WAIT_END: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!fpu_cmd_end && w_expire) begin
                        r_tmo <= 1'b1;
                    end
                end
                RD_SMP: begin
                    r_res[{r_idx[1:0], 3'b000} +: 8] <= fpu_data_i;
                end
                RD_GAP: begin
                    r_idx <= (r_idx == 4'd3) ? 4'd0 : r_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_result  = r_res;
    assign rsp_timeout = r_tmo;

endmodule

// File: tb/tb_fpu_seq.sv
// Self-checking bench for fpu_seq with a behavioural byte-bus FPU model.
module tb_fpu_seq;
    import pa_fpu::*;

    localparam int T  = 16;
    localparam int TL = 8192;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_op = 8'h00;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic [7:0]  fpu_data_o;
    logic [7:0]  fpu_data_i;
    logic [5:0]  fpu_addr;
    logic        fpu_cs_n;
    logic        fpu_rd_n;
    logic        fpu_wr_n;
    logic        fpu_end_ack;
    logic        m_cmd_end = 1'b0;
    logic        m_busy = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fpu_seq #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .fpu_data_o(fpu_data_o), .fpu_data_i(fpu_data_i),
        .fpu_addr(fpu_addr), .fpu_cs_n(fpu_cs_n),
        .fpu_rd_n(fpu_rd_n), .fpu_wr_n(fpu_wr_n),
        .fpu_end_ack(fpu_end_ack),
        .fpu_cmd_end(m_cmd_end), .fpu_busy(m_busy)
    );

    // Stub FPU arithmetic; the division case reproduces a real IEEE result.
    function automatic logic [31:0] fpu_func(logic [7:0] op,
                                             logic [31:0] a,
                                             logic [31:0] b);
        if (op == op_div && a == 32'h458ebf1f && b == 32'h449a522c)
            return 32'h406ccca7;
        case (op)
            op_add:  return a + b;
            op_sub:  return a - b;
            op_mul:  return a * b;
            op_div:  return a ^ {b[15:0], b[31:16]};
            default: return a ^ b ^ {4{op}};
        endcase
    endfunction

    // FPU model state and configuration
    int          cyc = 0;
    logic [7:0]  m_reg [16];
    logic [31:0] m_res = 32'h0;
    bit          m_armed = 0;
    int          m_cnt = 0;
    int          m_ackn = 0;
    int          cfg_w = 1;
    int          cfg_hold = 1;
    bit          cfg_never = 0;

    // Bus trace, indexed by cycle number
    logic [5:0] tr_addr [TL];
    logic [7:0] tr_data [TL];
    logic       tr_cs [TL];
    logic       tr_rd [TL];
    logic       tr_wr [TL];
    logic       tr_ack [TL];

    assign fpu_data_i = (!fpu_rd_n && fpu_addr[5:2] == 4'd3)
                      ? m_res[{fpu_addr[1:0], 3'b000} +: 8] : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc < TL) begin
            tr_addr[cyc] <= fpu_addr;
            tr_data[cyc] <= fpu_data_o;
            tr_cs[cyc]   <= fpu_cs_n;
            tr_rd[cyc]   <= fpu_rd_n;
            tr_wr[cyc]   <= fpu_wr_n;
            tr_ack[cyc]  <= fpu_end_ack;
        end
        if (arst) begin
            m_cmd_end <= 1'b0;
            m_busy    <= 1'b0;
            m_armed   <= 0;
            m_cnt     <= 0;
            m_ackn    <= 0;
        end else begin
            if (m_armed) begin
                if (m_cnt == 0) begin
                    m_cmd_end <= 1'b1;
                    m_busy    <= 1'b0;
                    m_armed   <= 0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (!fpu_cs_n && !fpu_wr_n) begin
                m_reg[fpu_addr[3:0]] <= fpu_data_o;
                if (fpu_addr == ADDR_OP) begin
                    m_res <= fpu_func(fpu_data_o,
                        {m_reg[3], m_reg[2], m_reg[1], m_reg[0]},
                        {m_reg[7], m_reg[6], m_reg[5], m_reg[4]});
                    m_ackn <= 0;
                    if (!cfg_never) begin
                        if (cfg_w == 0) begin
                            m_cmd_end <= 1'b1;
                        end else begin
                            m_armed <= 1;
                            m_cnt   <= cfg_w - 1;
                            m_busy  <= 1'b1;
                        end
                    end
                end
            end
            if (fpu_end_ack && m_cmd_end) begin
                m_ackn <= m_ackn + 1;
                if (m_ackn + 1 >= cfg_hold) m_cmd_end <= 1'b0;
            end
        end
    end

    // Read and write strobes must never be asserted together.
    always @(negedge clk) begin
        n_chk++;
        assert (!(!fpu_cs_n && !fpu_rd_n && !fpu_wr_n)) else begin
            n_fail++;
            $error("FAIL strobe_excl: observed cs/rd/wr=%b%b%b required not 000",
                   fpu_cs_n, fpu_rd_n, fpu_wr_n);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit chk_writes(int acc, logic [7:0] op,
                                      logic [31:0] a, logic [31:0] b);
        bit ok = 1;
        logic [7:0] eb;
        for (int k = 0; k < 9; k++) begin
            int c = acc + 1 + 2 * k;
            if (k < 4) eb = a[8*k +: 8];
            else if (k < 8) eb = b[8*(k-4) +: 8];
            else eb = op;
            if (tr_cs[c] !== 1'b0 || tr_wr[c] !== 1'b0 || tr_rd[c] !== 1'b1 ||
                tr_addr[c] !== 6'(k) || tr_data[c] !== eb) ok = 0;
            if (tr_cs[c+1] !== 1'b1 || tr_wr[c+1] !== 1'b1 ||
                tr_rd[c+1] !== 1'b1 || tr_addr[c+1] !== 6'(k) ||
                tr_data[c+1] !== eb) ok = 0;
        end
        return ok;
    endfunction

    function automatic bit chk_reads(int base);
        bit ok = 1;
        for (int j = 0; j < 4; j++) begin
            int c = base + 3 * j;
            for (int s = 0; s < 2; s++) begin
                if (tr_cs[c+s] !== 1'b0 || tr_rd[c+s] !== 1'b0 ||
                    tr_wr[c+s] !== 1'b1 || tr_addr[c+s] !== 6'(12 + j)) ok = 0;
            end
            if (tr_cs[c+2] !== 1'b1 || tr_rd[c+2] !== 1'b1 ||
                tr_wr[c+2] !== 1'b1) ok = 0;
        end
        return ok;
    endfunction

    function automatic int count_ack(int from, int to);
        int n = 0;
        for (int c = from; c < to; c++) if (tr_ack[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_rd(int from, int to);
        int n = 0;
        for (int c = from; c < to; c++) if (tr_rd[c] === 1'b0) n++;
        return n;
    endfunction

    // One full command; entered and left at a falling edge.
    task automatic txn(input string tag, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int w, input int hold, input int rdly,
                       input bit never, input bit nxt,
                       input logic [7:0] nop, input logic [31:0] na,
                       input logic [31:0] nb, output int acc, output int hs);
        int budget, lat, exp_lat, nw, base;
        bit rdy_bad, stable;
        logic [31:0] res0;
        logic tmo0;
        cfg_w = w; cfg_hold = hold; cfg_never = never;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        rsp_ready = 1'b0;
        budget = 0;
        while (!req_ready && budget < 200) begin
            @(negedge clk); budget++;
        end
        check({tag, "_accept"}, 32'(budget < 200), 32'd1);
        acc = cyc;
        @(posedge clk); #1;
        if (nxt) begin
            req_op = nop; req_a = na; req_b = nb;
        end else begin
            req_valid = 1'b0;
            req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
        end
        budget = 0; rdy_bad = 0;
        @(negedge clk);
        while (!rsp_valid && budget < 3000) begin
            if (req_ready) rdy_bad = 1;
            @(negedge clk); budget++;
        end
        check({tag, "_rsp"}, 32'(budget < 3000), 32'd1);
        lat = cyc - acc;
        nw = (w < 1) ? 1 : w;
        exp_lat = never ? 19 + T : 19 + nw + 12 + hold + 1;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdy_low"}, 32'(rdy_bad), 32'd0);
        check({tag, "_result"}, rsp_result,
              never ? 32'h0 : fpu_func(op, a, b));
        check({tag, "_timeout"}, 32'(rsp_timeout), 32'(never));
        check({tag, "_writes"}, 32'(chk_writes(acc, op, a, b)), 32'd1);
        if (never) begin
            check({tag, "_no_reads"}, 32'(count_rd(acc, cyc)), 32'd0);
            check({tag, "_no_ack"}, 32'(count_ack(acc, cyc)), 32'd0);
        end else begin
            base = acc + 19 + nw;
            check({tag, "_reads"}, 32'(chk_reads(base)), 32'd1);
            check({tag, "_ack_len"}, 32'(count_ack(acc, cyc)), 32'(hold + 1));
        end
        res0 = rsp_result; tmo0 = rsp_timeout; stable = 1;
        repeat (rdly) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== res0 ||
                rsp_timeout !== tmo0 || req_ready !== 1'b0) stable = 0;
        end
        if (rdly > 0) check({tag, "_hold"}, 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        hs = cyc;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int acc1, hs1, acc2, hs2, nwr8, w;
        logic [7:0] op;
        logic [7:0] ops [4];
        ops[0] = op_add; ops[1] = op_sub; ops[2] = op_mul; ops[3] = op_div;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_result", rsp_result, 32'h0);
        check("rst_strobes", 32'({fpu_cs_n, fpu_rd_n, fpu_wr_n}), 32'd7);
        check("rst_end_ack", 32'(fpu_end_ack), 32'd0);
        check("rst_addr", 32'(fpu_addr), 32'd0);
        check("rst_data", 32'(fpu_data_o), 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);

        // Directed divide
        txn("div", op_div, 32'h458ebf1f, 32'h449a522c, 3, 1, 0, 0,
            0, 8'h0, 32'h0, 32'h0, acc1, hs1);
        check("div_value", m_res, 32'h406ccca7);

        // Slow consumer and long cmd_end hold
        txn("slow", op_mul, $urandom, $urandom, 2, 2, 10, 0,
            0, 8'h0, 32'h0, 32'h0, acc1, hs1);

        // Back-to-back requests
        txn("b2b_1", op_add, 32'h11223344, 32'h55667788, 1, 1, 2, 0,
            1, op_sub, 32'hcafef00d, 32'h0badbeef, acc1, hs1);
        txn("b2b_2", op_sub, 32'hcafef00d, 32'h0badbeef, 0, 1, 0, 0,
            0, 8'h0, 32'h0, 32'h0, acc2, hs2);
        check("b2b_gap", 32'(acc2 - hs1), 32'd1);

        // Timeout, then cmd_end coinciding with expiry
        txn("tmo", op_add, $urandom, $urandom, 0, 1, 3, 1,
            0, 8'h0, 32'h0, 32'h0, acc1, hs1);
        txn("edge", op_div, $urandom, $urandom, T, 1, 0, 0,
            0, 8'h0, 32'h0, 32'h0, acc1, hs1);

        // Reset during the sixth write
        cfg_w = 1; cfg_hold = 1; cfg_never = 0;
        req_op = op_mul; req_a = $urandom; req_b = $urandom;
        req_valid = 1'b1;
        while (!req_ready) @(negedge clk);
        acc1 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_wr_addr", 32'({fpu_addr, fpu_wr_n}), 32'({6'd5, 1'b0}));
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        check("mid_strobes", 32'({fpu_cs_n, fpu_rd_n, fpu_wr_n}), 32'd7);
        check("mid_addr", 32'(fpu_addr), 32'd0);
        repeat (20) @(negedge clk);
        nwr8 = 0;
        for (int c = acc1; c < cyc; c++)
            if (tr_wr[c] === 1'b0 && tr_addr[c] === ADDR_OP) nwr8++;
        check("mid_no_op_wr", 32'(nwr8), 32'd0);
        check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        txn("fresh", op_add, $urandom, $urandom, 4, 1, 1, 0,
            0, 8'h0, 32'h0, 32'h0, acc1, hs1);

        // Randomized commands
        for (int i = 0; i < 12; i++) begin
            op = ops[$urandom_range(0, 3)];
            w  = $urandom_range(0, T);
            txn("rnd", op, $urandom, $urandom, w, $urandom_range(1, 3),
                $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
                0, 8'h0, 32'h0, 32'h0, acc1, hs1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
